// File: rtl/apb_cmd_master.sv
// apb_cmd_master: single-command APB requester.
// Accepts one read/write command at a time on a valid/ready port, runs one
// APB SETUP/ACCESS transfer to the slave selected by the top two address
// bits and returns the result on a response port that is held until
// consumed.
// Optional build macro APB_TIMEOUT_EN: abandons an ACCESS phase after
// TIMEOUT_CYCLES consecutive cycles without PREADY and reports an error.
module apb_cmd_master #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_SLAVES     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [3:0]            req_strb,
  input  logic [2:0]            req_prot,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [NUM_SLAVES-1:0] PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  output logic [3:0]            PSTRB,
  output logic [2:0]            PPROT,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  localparam int IDX_W = 2;

  // The timeout counter is 8 bits wide and the slave index field is 2 bits.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255 || NUM_SLAVES < 1 || NUM_SLAVES > 4)
  begin : g_bad_params
    $error("apb_cmd_master: TIMEOUT_CYCLES must be 1..255 and NUM_SLAVES 1..4");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic                  pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [3:0]            pstrb_q, pstrb_d;
  logic [2:0]            pprot_q, pprot_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;

`ifdef APB_TIMEOUT_EN
  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);
  logic [7:0]            wait_cnt_q, wait_cnt_d;
`endif

  logic [IDX_W-1:0] req_idx;
  logic [IDX_W-1:0] cur_idx;
  logic             req_idx_ok;
  logic             in_xfer;

  assign req_idx    = req_addr[ADDR_WIDTH-1 -: IDX_W];
  assign cur_idx    = paddr_q[ADDR_WIDTH-1 -: IDX_W];
  assign req_idx_ok = (int'(req_idx) < NUM_SLAVES);
  assign in_xfer    = (state_q == S_SETUP) || (state_q == S_ACCESS);

  // Outputs decoded from the registered state and command fields.
  always_comb begin
    PSEL = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      PSEL[i] = in_xfer && (int'(cur_idx) == i);
    end
  end

  assign req_ready = (state_q == S_IDLE) && !PRESET;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign PENABLE   = (state_q == S_ACCESS);
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign PSTRB     = pstrb_q;
  assign PPROT     = pprot_q;

  // Next-state and datapath update for the command/transfer/response cycle.
  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    pprot_d     = pprot_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef APB_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          paddr_d  = req_addr;
          pwrite_d = req_write;
          pwdata_d = req_wdata;
          pstrb_d  = req_write ? req_strb : 4'h0;
          pprot_d  = req_prot;
          if (req_idx_ok) begin
            state_d = S_SETUP;
          end else begin
            // Unmapped slave: answer immediately without touching the bus.
            state_d     = S_RESP;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end
        end
      end
      S_SETUP: begin
        state_d = S_ACCESS;
`ifdef APB_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end
      S_ACCESS: begin
        if (PREADY) begin
          state_d     = S_RESP;
          rsp_err_d   = PSLVERR;
          rsp_rdata_d = (!pwrite_q && !PSLVERR) ? PRDATA : '0;
        end
`ifdef APB_TIMEOUT_EN
        else if (wait_cnt_q + 8'd1 == TO_LIMIT) begin
          state_d     = S_RESP;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
`endif
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset also aborts any transfer in flight.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= S_IDLE;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      pprot_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef APB_TIMEOUT_EN
      wait_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      pprot_q     <= pprot_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef APB_TIMEOUT_EN
      wait_cnt_q  <= wait_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Testbench for apb_cmd_master: directed vector table, reset/stall sequences
// and random commands checked against a transaction-level reference model.
module tb_apb_cmd_master;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int NS = 3;
  localparam int TO = 4;
`ifdef APB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          PCLK = 1'b0;
  logic          PRESET;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [3:0]    req_strb;
  logic [2:0]    req_prot;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic [NS-1:0] PSEL;
  logic          PENABLE, PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [3:0]    PSTRB;
  logic [2:0]    PPROT;
  logic [DW-1:0] PRDATA;
  logic          PREADY, PSLVERR;

  int total = 0;
  int bad   = 0;

  apb_cmd_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS), .TIMEOUT_CYCLES(TO)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .req_prot(req_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  // ---------------- APB slave: RAM with programmable wait states ----------
  int          wait_cfg = 0;
  bit          err_cfg  = 1'b0;
  int          wcnt     = 0;
  logic [31:0] smem [4][16];

  assign PREADY  = (PSEL != '0) && PENABLE && (wcnt >= wait_cfg);
  assign PSLVERR = PREADY && err_cfg;
  assign PRDATA  = smem[PADDR[15:14]][PADDR[5:2]];

  always @(posedge PCLK) begin
    if ((PSEL != '0) && PENABLE && !PREADY) wcnt <= wcnt + 1;
    else wcnt <= 0;
    if (PREADY && PWRITE && !PSLVERR)
      for (int b = 0; b < 4; b++)
        if (PSTRB[b]) smem[PADDR[15:14]][PADDR[5:2]][8*b +: 8] <= PWDATA[8*b +: 8];
  end

  // ---------------- reference model ---------------------------------------
  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    int          waits;
    bit          serr;
    int          hold;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  logic [31:0] mmem [4][16];

  // Expected result and accept-to-response latency of one command.
  function automatic void model(input vec_t v, output logic e, output logic [31:0] rd,
                                output int lat);
    int idx = int'(v.addr[15:14]);
    int w   = int'(v.addr[5:2]);
    if (idx >= NS) begin
      e = 1'b1; rd = '0; lat = 1;
    end else if (TO_EN && v.waits >= TO) begin
      e = 1'b1; rd = '0; lat = TO + 2;
    end else begin
      lat = v.waits + 3;
      e   = v.serr;
      if (v.wr) begin
        rd = '0;
        if (!v.serr)
          for (int b = 0; b < 4; b++)
            if (v.strb[b]) mmem[idx][w][8*b +: 8] = v.wdata[8*b +: 8];
      end else begin
        rd = v.serr ? 32'h0 : mmem[idx][w];
      end
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", nm, got, exp);
    end
  endtask

  // Run one command through the DUT, checking bus phases and the response.
  task automatic run(input vec_t v, input logic exp_err, input logic [31:0] exp_rd,
                     input int exp_lat, input string nm);
    int            lat;
    int            idx;
    logic [NS-1:0] psel_seen;
    logic [NS-1:0] exp_psel;
    logic [3:0]    exp_strb;
    bit            bus_ok;
    bit            hold_ok;
    logic          e0;
    logic [31:0]   d0;
    idx      = int'(v.addr[15:14]);
    exp_psel = '0;
    if (idx < NS) exp_psel[idx] = 1'b1;
    exp_strb = v.wr ? v.strb : 4'h0;
    chk({nm, ".req_ready_idle"}, 32'(req_ready), 32'd1);
    wait_cfg  = v.waits;
    err_cfg   = v.serr;
    req_valid = 1'b1;
    req_write = v.wr;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    req_strb  = v.strb;
    req_prot  = v.prot;
    @(posedge PCLK); #1;
    req_valid = 1'b0;
    req_addr  = 16'($urandom);
    req_wdata = $urandom;
    lat       = 1;
    psel_seen = '0;
    bus_ok    = 1'b1;
    while (!rsp_valid && lat < 200) begin
      psel_seen |= PSEL;
      if (lat == 1 && idx < NS) begin
        chk({nm, ".setup_psel"},    32'(PSEL),    32'(exp_psel));
        chk({nm, ".setup_penable"}, 32'(PENABLE), 32'd0);
        chk({nm, ".setup_paddr"},   32'(PADDR),   32'(v.addr));
        chk({nm, ".setup_pwrite"},  32'(PWRITE),  32'(v.wr));
        chk({nm, ".setup_pstrb"},   32'(PSTRB),   32'(exp_strb));
        chk({nm, ".setup_pprot"},   32'(PPROT),   32'(v.prot));
      end
      if (PSEL != '0) begin
        if (PSEL !== exp_psel || PADDR !== v.addr || PWDATA !== v.wdata ||
            PSTRB !== exp_strb || PWRITE !== v.wr || PENABLE !== (lat >= 2))
          bus_ok = 1'b0;
      end
      if (req_ready) bus_ok = 1'b0;
      @(posedge PCLK); #1;
      lat++;
    end
    chk({nm, ".latency"}, 32'(lat), 32'(exp_lat));
    chk({nm, ".bus_stable"}, 32'(bus_ok), 32'd1);
    if (idx >= NS) chk({nm, ".no_psel"}, 32'(psel_seen), 32'd0);
    chk({nm, ".psel_drop"}, 32'({PSEL, PENABLE}), 32'd0);
    chk({nm, ".rsp_err"},   32'(rsp_err),   32'(exp_err));
    chk({nm, ".rsp_rdata"}, rsp_rdata, exp_rd);
    e0 = rsp_err;
    d0 = rsp_rdata;
    hold_ok = 1'b1;
    for (int k = 0; k < v.hold; k++) begin
      @(posedge PCLK); #1;
      if (!rsp_valid || rsp_err !== e0 || rsp_rdata !== d0 || req_ready) hold_ok = 1'b0;
    end
    if (v.hold > 0) chk({nm, ".rsp_hold"}, 32'(hold_ok), 32'd1);
    rsp_ready = 1'b1;
    @(posedge PCLK); #1;
    rsp_ready = 1'b0;
    chk({nm, ".rsp_done"}, 32'({rsp_valid, req_ready}), 32'b01);
  endtask

  vec_t dir [9];

  initial begin
    logic        e;
    logic [31:0] rd;
    int          lat;
    vec_t        v;
    bit          ok;

    for (int s = 0; s < 4; s++)
      for (int w = 0; w < 16; w++) begin
        smem[s][w] = '0;
        mmem[s][w] = '0;
      end
    PRESET = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_strb = '0; req_prot = '0; rsp_ready = 1'b0;

    //          wr    addr      wdata         strb  prot  wt serr hold err   rdata         lat
    dir[0] = '{1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 3'd0, 0, 1'b0, 0, 1'b0, 32'h00000000, 3};
    dir[1] = '{1'b0, 16'h0010, 32'h00000000, 4'hF, 3'd1, 3, 1'b0, 0, 1'b0, 32'hDEADBEEF, 6};
    dir[2] = '{1'b0, 16'hC000, 32'h00000000, 4'h0, 3'd0, 0, 1'b0, 0, 1'b1, 32'h00000000, 1};
    dir[3] = '{1'b0, 16'h4010, 32'h00000000, 4'h0, 3'd3, 0, 1'b1, 5, 1'b1, 32'h00000000, 3};
    dir[4] = '{1'b1, 16'h8024, 32'h11223344, 4'h5, 3'd5, 1, 1'b0, 0, 1'b0, 32'h00000000, 4};
    dir[5] = '{1'b0, 16'h8024, 32'hFFFFFFFF, 4'hF, 3'd2, 0, 1'b0, 2, 1'b0, 32'h00220044, 3};
    dir[6] = '{1'b1, 16'hC004, 32'hCAFEF00D, 4'hF, 3'd7, 0, 1'b0, 1, 1'b1, 32'h00000000, 1};
    dir[7] = '{1'b1, 16'h4000, 32'hAAAAAAAA, 4'hF, 3'd0, 2, 1'b1, 0, 1'b1, 32'h00000000, 5};
    dir[8] = '{1'b0, 16'h4000, 32'h00000000, 4'hF, 3'd0, 0, 1'b0, 0, 1'b0, 32'h00000000, 3};

    repeat (3) @(posedge PCLK);
    #1;
    chk("reset.outputs", 32'({req_ready, rsp_valid, PENABLE, PWRITE, rsp_err}), 32'd0);
    chk("reset.psel",  32'(PSEL),  32'd0);
    chk("reset.paddr", 32'(PADDR), 32'd0);
    chk("reset.rdata", rsp_rdata,  32'd0);
    PRESET = 1'b0;
    #1;

    for (int i = 0; i < 9; i++) begin
      model(dir[i], e, rd, lat);
      run(dir[i], dir[i].exp_err, dir[i].exp_rdata, dir[i].exp_lat, $sformatf("dir%0d", i));
    end

    // Reset in the middle of an ACCESS phase of a write.
    wait_cfg = 10; err_cfg = 1'b0;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0020;
    req_wdata = 32'h12345678; req_strb = 4'hF; req_prot = 3'd0;
    @(posedge PCLK); #1;
    req_valid = 1'b0;
    @(posedge PCLK); #1;
    @(posedge PCLK); #1;
    chk("rstabort.in_access", 32'({PSEL, PENABLE}), 32'b0011);
    PRESET = 1'b1;
    @(posedge PCLK); #1;
    chk("rstabort.bus_low", 32'({PSEL, PENABLE, rsp_valid}), 32'd0);
    PRESET = 1'b0;
    #1;
    chk("rstabort.req_ready", 32'(req_ready), 32'd1);
    ok = 1'b1;
    repeat (3) begin
      @(posedge PCLK); #1;
      if (rsp_valid || PSEL != '0 || PENABLE) ok = 1'b0;
    end
    chk("rstabort.quiet", 32'(ok), 32'd1);
    v = '{1'b0, 16'h0020, 32'h0, 4'hF, 3'd0, 0, 1'b0, 0, 1'b0, 32'h0, 0};
    model(v, e, rd, lat);
    run(v, e, rd, lat, "rstabort.readback");

`ifdef APB_TIMEOUT_EN
    v = '{1'b0, 16'h4008, 32'h0, 4'h0, 3'd0, 1000, 1'b0, 1, 1'b0, 32'h0, 0};
    run(v, 1'b1, 32'h0, TO + 2, "timeout.read");
    v = '{1'b1, 16'h0008, 32'h55AA55AA, 4'hF, 3'd0, TO, 1'b0, 0, 1'b0, 32'h0, 0};
    model(v, e, rd, lat);
    run(v, 1'b1, 32'h0, TO + 2, "timeout.write_at_limit");
`else
    wait_cfg = 1000; err_cfg = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0000; req_prot = 3'd0;
    @(posedge PCLK); #1;
    req_valid = 1'b0;
    @(posedge PCLK); #1;
    ok = 1'b1;
    repeat (100) begin
      if (PSEL !== 3'b001 || !PENABLE || rsp_valid) ok = 1'b0;
      @(posedge PCLK); #1;
    end
    chk("stall.still_access", 32'(ok), 32'd1);
    chk("stall.no_rsp", 32'({rsp_valid, req_ready}), 32'd0);
    PRESET = 1'b1;
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    #1;
`endif

    for (int i = 0; i < 40; i++) begin
      v.wr    = 1'($urandom_range(0, 1));
      v.addr  = {2'($urandom_range(0, 3)), 14'($urandom)};
      v.wdata = $urandom;
      v.strb  = 4'($urandom);
      v.prot  = 3'($urandom);
      v.waits = $urandom_range(0, 5);
      v.serr  = ($urandom_range(0, 3) == 0);
      v.hold  = $urandom_range(0, 2);
      model(v, e, rd, lat);
      run(v, e, rd, lat, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got=running expected=done");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/apb_cmd_master.md
Name: apb_cmd_master

Overview:
- Upstream APB requester that feeds the RAM-backed APB slaves.
- Accepts single read/write commands on a valid/ready request port and runs one APB transfer per command (SETUP then ACCESS).
- Decodes the top address bits into a one-hot PSEL vector and returns read data and error status on a held response port.
- Sits between the processor/test-sequencer command source and up to four APB slave wrappers.

Parameters:
ADDR_WIDTH, 16, PADDR/req_addr width; top 2 bits are the slave index.
DATA_WIDTH, 32, PWDATA/PRDATA width.
NUM_SLAVES, 4, populated slaves, 1..4; index >= NUM_SLAVES is a decode error.
TIMEOUT_CYCLES, 255, max ACCESS wait cycles (APB_TIMEOUT_EN only); 8-bit counter.

Ports:
PCLK  in  1  clock
PRESET  in  1  synchronous reset, active-high
req_valid  in  1  command valid
req_ready  out  1  command accepted when valid&&ready
req_write  in  1  1=write, 0=read
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  DATA_WIDTH  write data
req_strb  in  4  byte strobes (writes; forced 0 on reads)
req_prot  in  3  protection attributes
rsp_valid  out  1  response valid, held until rsp_ready
rsp_ready  in  1  response consumed
rsp_rdata  out  DATA_WIDTH  read data (0 for writes and errors)
rsp_err  out  1  PSLVERR, decode error or timeout
PSEL  out  NUM_SLAVES  one-hot slave select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PADDR  out  ADDR_WIDTH  APB address
PWDATA  out  DATA_WIDTH  APB write data
PSTRB  out  4  APB strobes
PPROT  out  3  APB protection
PRDATA  in  DATA_WIDTH  muxed slave read data
PREADY  in  1  muxed slave ready
PSLVERR  in  1  muxed slave error, sampled with PREADY

Behaviour:
- Reset (PRESET=1 at a rising PCLK edge): all outputs 0, state IDLE, response slot empty; takes priority over everything, including aborting an in-flight transfer (PSEL/PENABLE low next cycle, no response issued).
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - req_ready = 1 only in IDLE (response slot is always empty there).
  - On accept, command fields are registered into PADDR/PWRITE/PWDATA/PSTRB/PPROT.
  - Valid slave index: go to SETUP.
  - Index >= NUM_SLAVES: go to RESP with rsp_err=1, rsp_rdata=0; no PSEL asserted.
- SETUP: exactly one cycle; PSEL[idx]=1, PENABLE=0. Always goes to ACCESS.
- ACCESS:
  - PSEL[idx]=1, PENABLE=1.
  - APB outputs stay stable from SETUP until PREADY is sampled high.
  - PREADY=1: capture rsp_rdata = PRDATA on reads, 0 on writes; rsp_err = PSLVERR; go to RESP.
  - PSEL and PENABLE drop in the cycle after PREADY.
- RESP: rsp_valid=1 with data and err stable; leave to IDLE on the cycle rsp_ready=1.
- Latency with zero-wait slave and rsp_ready=1: accept at cycle 0, SETUP 1, ACCESS 2, rsp_valid 3, next accept 4. Every wait state adds one cycle.
- In IDLE, PADDR/PWDATA/PSTRB/PPROT/PWRITE hold their last values; PSEL and PENABLE are 0.
- Read commands drive PSTRB=0 regardless of req_strb.
- No back-to-back SETUP without passing through IDLE.
- req_valid is ignored while req_ready=0.

Optional Feature:
APB_TIMEOUT_EN:
- Defined: an 8-bit counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0. When the count equals TIMEOUT_CYCLES, the transfer is abandoned: PSEL/PENABLE low next cycle, RESP with rsp_err=1, rsp_rdata=0.
- PREADY=1 in the same cycle as the limit counts as a normal completion.
- Undefined: no counter; ACCESS waits indefinitely for PREADY.

Test Plan:
- Write req_addr=0x0010, wdata=0xDEADBEEF, strb=0xF, zero-wait slave 0 -> PSEL=0001 at cycles 1-2, PENABLE only at cycle 2, rsp_valid at cycle 3 with err=0, rdata=0.
- Read 0x0010 after the write, slave inserts 3 wait states -> ACCESS lasts 4 cycles, PADDR stable throughout, rsp_rdata=0xDEADBEEF at cycle 6, PSTRB=0.
- NUM_SLAVES=2, read 0xC000 -> no PSEL pulse, rsp_valid next cycle, rsp_err=1, rdata=0.
- Slave returns PSLVERR=1 with PREADY, and rsp_ready held low 5 cycles -> rsp_err=1 held stable, req_ready=0 until rsp_ready=1.
- Assert PRESET during ACCESS of a write -> PSEL/PENABLE=0 the following cycle, no rsp_valid, req_ready=1 after reset release.
- APB_TIMEOUT_EN, TIMEOUT_CYCLES=4, PREADY stuck low -> abort after 4 ACCESS cycles, rsp_err=1; same bench without the macro -> still in ACCESS after 100 cycles.
